// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline control state encoding and default sizes
package pipe_ctrl_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int NUM_STAGES_DEF = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } pipe_state_e;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: programmable 50%-duty divider producing whole control-clock periods on request
module clk_div_core import pipe_ctrl_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  output logic             cntl_clk,
  output logic             cntl_tick,
  output logic             div_err,
  output logic             active,
  output logic             period_start,
  output logic             period_end
);
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_cnt;
  logic             last;
  assign last         = phase_cnt == div_q - 1'b1;
  assign period_end   = active && !cntl_clk && last;
  assign period_start = en && (!active || period_end);
  // a new period starts only from idle or exactly at the end of a low phase
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      cntl_clk  <= 1'b0;
      cntl_tick <= 1'b0;
      div_err   <= 1'b0;
      active    <= 1'b0;
      phase_cnt <= '0;
      div_q     <= DIV_W'(1);
    end else if (period_start) begin
      cntl_clk  <= 1'b1;
      cntl_tick <= 1'b1;
      active    <= 1'b1;
      phase_cnt <= '0;
      div_q     <= (div_i == '0) ? DIV_W'(1) : div_i;
      div_err   <= div_i == '0;
    end else begin
      cntl_tick <= 1'b0;
      if (active) begin
        phase_cnt <= last ? '0 : phase_cnt + 1'b1;
        if (last) begin
          cntl_clk <= 1'b0;
          active   <= cntl_clk;
        end
      end
    end
endmodule

// File: rtl/pipe_phase_gen.sv
// pipe_phase_gen: control clock, stage-enable ring and run/stop/step control for the pipeline
module pipe_phase_gen import pipe_ctrl_pkg::*; #(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int IDX_W      = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  run_i,
  input  logic                  step_i,
  input  logic [DIV_W-1:0]      div_i,
  output logic                  cntl_clk,
  output logic                  cntl_tick,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  busy,
  output logic                  div_err
);
  pipe_state_e state, state_nxt;
  logic        en, active, period_start, period_end, done;
  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .en          (en),
    .div_i       (div_i),
    .cntl_clk    (cntl_clk),
    .cntl_tick   (cntl_tick),
    .div_err     (div_err),
    .active      (active),
    .period_start(period_start),
    .period_end  (period_end)
  );
  assign done     = period_end || !active;
  assign busy     = state != IDLE;
  assign stage_en = busy ? NUM_STAGES'(1) << stage_idx : '0;
  // next state and period request; DRAIN behaves as RUN with run_i low
  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    case (state)
      IDLE:       state_nxt = run_i ? RUN : step_i ? STEP : IDLE;
      RUN, DRAIN: begin
        en        = run_i;
        state_nxt = run_i ? RUN : done ? IDLE : DRAIN;
      end
      STEP: begin
        en        = run_i || !active;
        state_nxt = period_end ? (run_i ? RUN : IDLE) : STEP;
      end
      default:    state_nxt = IDLE;
    endcase
  end
  // state register and stage ring; the first tick after IDLE keeps the stored stage
  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      stage_idx <= '0;
    end else begin
      state <= state_nxt;
      if (period_start && active)
        stage_idx <= (stage_idx == IDX_W'(NUM_STAGES - 1)) ? '0 : stage_idx + 1'b1;
    end
endmodule

// File: tb/tb_pipe_phase_gen.sv
// tb_pipe_phase_gen: scoreboard bench with a period-position reference model
module tb_pipe_phase_gen;
  localparam int N = 4;
  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run_i   = 1'b0;
  logic       step_i  = 1'b0;
  logic [7:0] div_i   = 8'd1;
  logic       cntl_clk, cntl_tick, busy, div_err;
  logic [3:0] stage_en;
  logic [1:0] stage_idx;
  typedef struct packed {
    logic       clk;
    logic       tick;
    logic       busy;
    logic       err;
    logic [3:0] en;
    logic [1:0] idx;
  } exp_t;
  exp_t q[$];
  exp_t e_m, got_m;
  int   tests = 0;
  int   fails = 0;
  int   m_mode, m_pos, m_d, m_idx;
  logic m_err;
  pipe_phase_gen #(.DIV_W(8), .NUM_STAGES(N), .IDX_W(2)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .run_i    (run_i),
    .step_i   (step_i),
    .div_i    (div_i),
    .cntl_clk (cntl_clk),
    .cntl_tick(cntl_tick),
    .stage_en (stage_en),
    .stage_idx(stage_idx),
    .busy     (busy),
    .div_err  (div_err)
  );
  always #5 sys_clk = ~sys_clk;
  // mode: 0 idle, 1 running or draining, 3 single step; pos: cycle within period, -1 none
  function automatic void m_reset();
    m_mode = 0;
    m_pos  = -1;
    m_d    = 1;
    m_idx  = 0;
    m_err  = 1'b0;
  endfunction
  function automatic void m_step(logic run, logic step, logic [7:0] div);
    logic last, done, cont;
    int   nm;
    last = m_pos == 2 * m_d - 1;
    done = m_pos < 0 || last;
    cont = (m_mode != 0 && run) || (m_mode == 3 && m_pos < 0);
    nm = m_mode == 0 ? (run ? 1 : step ? 3 : 0) :
         m_mode == 1 ? ((run || !done) ? 1 : 0) :
         (last ? (run ? 1 : 0) : 3);
    if (done && cont) begin
      if (m_pos >= 0) m_idx = (m_idx + 1) % N;
      m_pos = 0;
      m_d   = div == 8'd0 ? 1 : int'(div);
      m_err = div == 8'd0;
    end else if (last) m_pos = -1;
    else if (m_pos >= 0) m_pos++;
    m_mode = nm;
  endfunction
  function automatic exp_t m_out();
    exp_t e;
    e.clk  = m_pos >= 0 && m_pos < m_d;
    e.tick = m_pos == 0;
    e.busy = m_mode != 0;
    e.err  = m_err;
    e.idx  = 2'(m_idx);
    e.en   = e.busy ? 4'(1 << m_idx) : 4'b0;
    return e;
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic cyc(logic run, logic step, logic [7:0] div);
    @(negedge sys_clk);
    reset_n = 1'b1;
    run_i   = run;
    step_i  = step;
    div_i   = div;
    m_step(run, step, div);
    q.push_back(m_out());
  endtask
  task automatic rst_mid();
    @(negedge sys_clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {cntl_clk, cntl_tick, busy, div_err, stage_en}, 0);
    chk("async_reset_idx", stage_idx, 0);
    m_reset();
  endtask
  // monitor: compare every post-edge output against the queued prediction
  always @(posedge sys_clk) begin
    #1;
    if (q.size() > 0) begin
      e_m   = q.pop_front();
      got_m = {cntl_clk, cntl_tick, busy, div_err, stage_en, stage_idx};
      tests++;
      if (got_m !== e_m) begin
        fails++;
        $display("FAIL cycle_check: got clk=%b tick=%b busy=%b err=%b en=%b idx=%0d expected clk=%b tick=%b busy=%b err=%b en=%b idx=%0d at %0t",
                 got_m.clk, got_m.tick, got_m.busy, got_m.err, got_m.en, got_m.idx,
                 e_m.clk, e_m.tick, e_m.busy, e_m.err, e_m.en, e_m.idx, $time);
      end
    end
  end
  initial begin
    logic [3:0] seq [5];
    logic       r;
    logic [7:0] d;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    m_reset();
    #1 chk("reset_outputs", {cntl_clk, cntl_tick, busy, div_err, stage_en, stage_idx}, 0);
    cyc(1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1);
      @(posedge sys_clk);
      #2 chk("div1_tick", cntl_tick, 1);
      chk("div1_stage_en", stage_en, seq[k]);
      cyc(1, 0, 1);
      @(posedge sys_clk);
      #2 chk("div1_low", {cntl_clk, cntl_tick}, 0);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 3);
    for (int i = 0; i < 16; i++) cyc(1, 0, 5);
    for (int i = 0; i < 12; i++) cyc(1, 0, 4);
    cyc(0, 0, 4);
    for (int i = 0; i < 16; i++) cyc(0, 0, 4);
    for (int i = 0; i < 30 && m_idx != 2; i++) begin
      cyc(0, 1, 2);
      for (int j = 0; j < 5; j++) cyc(0, 0, 2);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 2);
      for (int j = 0; j < 6; j++) cyc(0, 0, 2);
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 2);
    for (int i = 0; i < 7; i++) cyc(1, 0, 3);
    rst_mid();
    cyc(1, 0, 3);
    @(posedge sys_clk);
    #2 chk("release_no_tick", {cntl_tick, busy}, 2'b01);
    cyc(1, 0, 3);
    @(posedge sys_clk);
    #2 chk("release_first_tick", cntl_tick, 1);
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) r = ~r;
      d = ($urandom_range(40) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(4));
      if ($urandom_range(700) == 0) rst_mid();
      else cyc(r, $urandom_range(11) == 0, d);
    end
    cyc(0, 0, 1);
    @(posedge sys_clk);
    #3 chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
